fifo_pack_reader: RTL and testbench

- Drains a show-ahead FIFO (empty flag, read enable, data valid whenever not empty) and packs RATIO consecutive narrow words into one wide word.
- Presents the packed word on a valid/ready stream.
- Sits directly downstream of the team's dual-port SRAM FIFO, between the FIFO and wide consumers (bus writer, DMA beat builder).
- A flush input forces out a partially filled wide word, with per-lane keep bits.

---
 rtl/fifo_pack_reader.sv | 97 +++++++++
 tb/tb_fifo_pack_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack_reader.sv
// Drains a show-ahead FIFO and packs RATIO narrow words into one wide word on a valid/ready stream.
// Flush emits a partially filled word, with keep bits marking the lanes that hold data.
module fifo_pack_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH-1:0]       fifo_data_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  input  logic                   flush_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [WIDTH*RATIO-1:0] m_data_o,
  output logic [RATIO-1:0]       m_keep_o
);

  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned OW = WIDTH * RATIO;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0]               cnt_q, cnt_d;
  logic [RATIO-2:0][WIDTH-1:0] acc_q, acc_d;
  logic [OW-1:0]               data_q, data_d;
  logic [RATIO-1:0]            keep_q, keep_d;
  logic                        valid_q, valid_d;
  logic                        out_free, last, pop, emit;

  // The last lane may only be popped when the packed word can leave this cycle.
  assign out_free = ~valid_q | m_ready_i;
  assign last     = (cnt_q == LAST);
  assign pop      = ~fifo_empty_i & (~last | out_free);
  assign emit     = out_free & ((pop & last) | (flush_i & ((cnt_q != '0) | pop)));

  assign fifo_rd_en_o = pop;
  assign m_valid_o    = valid_q;
  assign m_data_o     = data_q;
  assign m_keep_o     = keep_q;

  // Next-state: either emit (with the current pop merged in) or fill the next lane.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    if (emit) begin
      data_d = '0;
      keep_d = '0;
      for (int k = 0; k < RATIO - 1; k++) begin
        if (cnt_q > CW'(k)) begin
          data_d[k*WIDTH +: WIDTH] = acc_q[k];
          keep_d[k]                = 1'b1;
        end
      end
      for (int k = 0; k < RATIO; k++) begin
        if (pop && (cnt_q == CW'(k))) begin
          data_d[k*WIDTH +: WIDTH] = fifo_data_i;
          keep_d[k]                = 1'b1;
        end
      end
      valid_d = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if (valid_q && m_ready_i) begin
        valid_d = 1'b0;
      end
      if (pop) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (cnt_q == CW'(k)) begin
            acc_d[k] = fifo_data_i;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Bench for fifo_pack_reader: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_pack_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OW    = WIDTH * RATIO;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_empty_i;
  logic             fifo_rd_en_o;
  logic             flush_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [OW-1:0]    m_data_o;
  logic [RATIO-1:0] m_keep_o;

  fifo_pack_reader #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_rd_en_o(fifo_rd_en_o),
    .flush_i     (flush_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_keep_o    (m_keep_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model: external FIFO contents, words gathered for the current wide word, output register.
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] pend[$];
  logic             mv;
  logic [OW-1:0]    mw;
  logic [RATIO-1:0] mk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    fq.delete();
    mv = 1'b0;
    mw = '0;
    mk = '0;
  endtask

  task automatic push_words(input logic [WIDTH-1:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + WIDTH'(i));
  endtask

  // One clock: drive inputs, compare DUT against model, then advance the model across the edge.
  task automatic step(input bit fl, input bit rdy);
    bit               free, pop, em;
    int               n;
    logic [WIDTH-1:0] w;
    @(negedge clk_i);
    flush_i      = fl;
    m_ready_i    = rdy;
    fifo_empty_i = (fq.size() == 0);
    fifo_data_i  = (fq.size() != 0) ? fq[0] : WIDTH'($urandom);
    #1;
    free = !mv || rdy;
    pop  = (fq.size() != 0) && ((pend.size() != RATIO - 1) || free);
    chk("rd_en", 64'(fifo_rd_en_o), 64'(pop));
    chk("valid", 64'(m_valid_o), 64'(mv));
    if (mv) begin
      chk("data", 64'(m_data_o), 64'(mw));
      chk("keep", 64'(m_keep_o), 64'(mk));
    end
    w = '0;
    if (pop) w = fq.pop_front();
    n  = pend.size() + int'(pop);
    em = free && ((pop && (pend.size() == RATIO - 1)) || (fl && (n > 0)));
    if (em) begin
      mw = '0;
      foreach (pend[i]) mw = mw | (OW'(pend[i]) << (i * WIDTH));
      if (pop) mw = mw | (OW'(w) << ((n - 1) * WIDTH));
      mk = RATIO'((1 << n) - 1);
      pend.delete();
      mv = 1'b1;
    end else begin
      if (mv && rdy) mv = 1'b0;
      if (pop) pend.push_back(w);
    end
  endtask

  // Just after the next edge, confirm a specific packed word from the scenario list.
  task automatic expect_out(input string tag, input logic [OW-1:0] d, input logic [RATIO-1:0] k);
    @(posedge clk_i);
    #1;
    chk({tag, "_valid"}, 64'(m_valid_o), 64'd1);
    chk({tag, "_data"}, 64'(m_data_o), 64'(d));
    chk({tag, "_keep"}, 64'(m_keep_o), 64'(k));
  endtask

  initial begin
    rst_ni       = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    flush_i      = 1'b0;
    m_ready_i    = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_data", 64'(m_data_o), 64'd0);
    chk("rst_keep", 64'(m_keep_o), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Four words packed into one full word
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    expect_out("tp1", 32'h44332211, 4'b1111);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Back-to-back stream
    push_words(8'h01, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    expect_out("tp2a", 32'h04030201, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    expect_out("tp2b", 32'h08070605, 4'b1111);
    step(1'b0, 1'b1);

    // Backpressure stalls the last lane
    push_words(8'hA1, 8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("tp3_stall_rd_en", 64'(fifo_rd_en_o), 64'd0);
    chk("tp3_held_data", 64'(m_data_o), 64'h00000000A4A3A2A1);
    step(1'b0, 1'b1);
    expect_out("tp3", 32'hA8A7A6A5, 4'b1111);
    step(1'b0, 1'b1);

    // Flush of a two-lane partial word, then flush with nothing held
    fq.push_back(8'hC1); fq.push_back(8'hC2);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    expect_out("tp4", 32'h0000C2C1, 4'b0011);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("tp4_no_empty_word", 64'(m_valid_o), 64'd0);

    // Flush coinciding with a pop
    fq.push_back(8'hD1); fq.push_back(8'hD2); fq.push_back(8'hD3);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    expect_out("tp5", 32'h00D3D2D1, 4'b0111);
    step(1'b0, 1'b1);
    push_words(8'hE1, 4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    expect_out("tp5_after", 32'hE4E3E2E1, 4'b1111);
    step(1'b0, 1'b1);

    // Blocked flush lets the partial word grow to full
    push_words(8'hB1, 8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    expect_out("tp7", 32'hB8B7B6B5, 4'b1111);
    step(1'b0, 1'b1);

    // Asynchronous reset mid-word with output pending
    push_words(8'hF1, 6);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    @(posedge clk_i);
    #2;
    fifo_empty_i = 1'b1;
    flush_i      = 1'b0;
    rst_ni       = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(m_valid_o), 64'd0);
    chk("arst_data", 64'(m_data_o), 64'd0);
    chk("arst_keep", 64'(m_keep_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    push_words(8'h91, 4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    expect_out("tp6", 32'h94939291, 4'b1111);
    step(1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 60) fq.push_back(WIDTH'($urandom));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
